// File: rtl/instr_cycle_sequencer_pkg.sv
// Shared control definitions for the MK5303 instruction sequencer:
// phase encodings, opcode classes, addressing modes and phase lengths.
package mk5303_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_SRC    = 3'd3,
        ST_DST    = 3'd4,
        ST_EXEC   = 3'd5,
        ST_WB     = 3'd6,
        ST_HALT   = 3'd7
    } state_e;

    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [1:0] MODE_REG = 2'b00;  // register, no memory operand
    localparam logic [1:0] MODE_IMM = 2'b01;  // immediate
    localparam logic [1:0] MODE_IND = 2'b10;  // memory indirect
    localparam logic [1:0] MODE_IDX = 2'b11;  // indexed

    localparam int LEN_W = 3;

    function automatic logic is_class_a(input logic [5:0] op);
        case (op)
            6'h00, 6'h01, 6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h20, 6'h21, 6'h22: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic is_class_b(input logic [5:0] op);
        case (op)
            6'h10, 6'h11, 6'h12, 6'h15, 6'h2A, 6'h33: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    // Indirect sources need one extra step for class A opcodes; class B
    // and unclassified opcodes share the shorter form.
    function automatic logic [LEN_W-1:0] src_len(input logic [5:0] op,
                                                 input logic [1:0] mode);
        case (mode)
            MODE_REG: return LEN_W'(0);
            MODE_IMM: return LEN_W'(2);
            MODE_IND: return is_class_a(op) ? LEN_W'(4) : LEN_W'(3);
            default:  return LEN_W'(4);
        endcase
    endfunction

    function automatic logic [LEN_W-1:0] dst_len(input logic [1:0] mode);
        return (mode == MODE_REG) ? LEN_W'(0) : LEN_W'(2);
    endfunction

endpackage

// File: rtl/instr_cycle_sequencer_if.sv
// Core-side bundle of the instruction sequencer: IR fields, memory
// handshake and the phase/step timing outputs.
interface instr_cycle_sequencer_if #(parameter int STEP_W = 3);

    logic                   start;
    logic [5:0]             opcode;
    logic [1:0]             src_mode;
    logic [1:0]             dst_mode;
    logic                   mem_ack;
    logic [2:0]             state;
    logic [STEP_W-1:0]      step;
    logic [2**STEP_W-1:0]   t_onehot;
    logic                   busy;
    logic                   mem_req;
    logic                   mem_we;
    logic                   ir_load;
    logic                   reg_we;
    logic                   done;
    logic                   illegal;
    logic                   bus_err;
    logic                   halted;

    modport slave (
        input  start, opcode, src_mode, dst_mode, mem_ack,
        output state, step, t_onehot, busy, mem_req, mem_we, ir_load,
               reg_we, done, illegal, bus_err, halted
    );

    modport master (
        output start, opcode, src_mode, dst_mode, mem_ack,
        input  state, step, t_onehot, busy, mem_req, mem_we, ir_load,
               reg_we, done, illegal, bus_err, halted
    );

endinterface

// File: rtl/instr_cycle_sequencer_mem_wait_timer.sv
// Counts cycles a memory request waits for its ack and flags a timeout
// when the count reaches MEM_TIMEOUT. MEM_TIMEOUT=0 disables it.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ack,
    input  logic clr,
    output logic timeout
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_v;

    // Count unanswered request cycles; an ack or a phase change restarts.
    always_comb begin
        ack_v = req && ack;
        cnt_d = cnt_q;
        if (clr || ack_v)
            cnt_d = '0;
        else if (req && (MEM_TIMEOUT != 0) && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + CNT_W'(1);
        // An ack arriving in the limit cycle wins over the timeout.
        timeout = (MEM_TIMEOUT != 0) && req && !ack_v && (cnt_q == CNT_MAX);
    end

    // Wait counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/instr_cycle_sequencer.sv
// Multicycle instruction control FSM for the MK5303 core.
//
//  state  | meaning
//  IDLE   | waiting for start
//  FETCH  | instruction read, IR loads on ack
//  DECODE | latch IR fields, choose first operand phase
//  SRC    | source operand steps, last step reads memory
//  DST    | destination operand steps, last step reads memory
//  EXEC   | single execute cycle
//  WB     | register write, or memory write held until ack
//  HALT   | stopped until reset
module instr_cycle_sequencer
    import mk5303_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int STEP_W      = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    instr_cycle_sequencer_if.slave   bus
);

    localparam int T_W = 2**STEP_W;

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [5:0]        opcode_q, opcode_d;
    logic [1:0]        src_mode_q, src_mode_d;
    logic [1:0]        dst_mode_q, dst_mode_d;

    logic [LEN_W-1:0]  cur_src_len, cur_dst_len, dec_src_len, dec_dst_len;
    logic              last_src, last_dst, mem_req, timeout;

    // Phase lengths of the latched instruction and request qualification.
    always_comb begin
        cur_src_len = src_len(opcode_q, src_mode_q);
        cur_dst_len = dst_len(dst_mode_q);
        last_src    = (step_q == STEP_W'(cur_src_len - LEN_W'(1)));
        last_dst    = (step_q == STEP_W'(cur_dst_len - LEN_W'(1)));
        case (state_q)
            ST_FETCH: mem_req = 1'b1;
            ST_SRC:   mem_req = last_src;
            ST_DST:   mem_req = last_dst;
            ST_WB:    mem_req = (dst_mode_q != MODE_REG);
            default:  mem_req = 1'b0;
        endcase
    end

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .req     (mem_req),
        .ack     (bus.mem_ack),
        .clr     (state_d != state_q),
        .timeout (timeout)
    );

    // Next phase, step and latched IR fields.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        opcode_d    = opcode_q;
        src_mode_d  = src_mode_q;
        dst_mode_d  = dst_mode_q;
        dec_src_len = src_len(bus.opcode, bus.src_mode);
        dec_dst_len = dst_len(bus.dst_mode);
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_FETCH;
            ST_FETCH: begin
                if (bus.mem_ack)  state_d = ST_DECODE;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_DECODE: begin
                opcode_d   = bus.opcode;
                src_mode_d = bus.src_mode;
                dst_mode_d = bus.dst_mode;
                if (bus.opcode == OP_HALT)         state_d = ST_HALT;
                else if (bus.dst_mode == MODE_IMM) state_d = ST_IDLE;
                else if (dec_src_len != '0)        state_d = ST_SRC;
                else if (dec_dst_len != '0)        state_d = ST_DST;
                else                               state_d = ST_EXEC;
            end
            ST_SRC: begin
                if (!last_src)    step_d  = step_q + STEP_W'(1);
                else if (bus.mem_ack)
                    state_d = (cur_dst_len != '0) ? ST_DST : ST_EXEC;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_DST: begin
                if (!last_dst)         step_d  = step_q + STEP_W'(1);
                else if (bus.mem_ack)  state_d = ST_EXEC;
                else if (timeout)      state_d = ST_IDLE;
            end
            ST_EXEC: state_d = ST_WB;
            ST_WB: begin
                if (dst_mode_q == MODE_REG || bus.mem_ack)
                    state_d = bus.start ? ST_FETCH : ST_IDLE;
                else if (timeout)
                    state_d = ST_IDLE;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q) step_d = '0;
    end

    // Phase, step and IR field registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            opcode_q   <= '0;
            src_mode_q <= '0;
            dst_mode_q <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            opcode_q   <= opcode_d;
            src_mode_q <= src_mode_d;
            dst_mode_q <= dst_mode_d;
        end
    end

    // Strobes decoded from the registered phase; illegal must react to the
    // IR fields during DECODE, before they are latched.
    always_comb begin
        bus.state    = state_q;
        bus.step     = step_q;
        bus.busy     = (state_q != ST_IDLE) && (state_q != ST_HALT);
        bus.t_onehot = bus.busy ? (T_W'(1) << step_q) : '0;
        bus.mem_req  = mem_req;
        bus.mem_we   = (state_q == ST_WB) && mem_req;
        bus.ir_load  = (state_q == ST_FETCH) && bus.mem_ack;
        bus.reg_we   = (state_q == ST_WB) && (dst_mode_q == MODE_REG);
        bus.done     = (state_q == ST_WB) &&
                       ((dst_mode_q == MODE_REG) || bus.mem_ack);
        bus.illegal  = (state_q == ST_DECODE) && (bus.opcode != OP_HALT) &&
                       (bus.dst_mode == MODE_IMM);
        bus.bus_err  = timeout;
        bus.halted   = (state_q == ST_HALT);
    end

endmodule
